frame_update_scheduler: RTL and testbench
=========================================

Name: frame_update_scheduler

Overview:
Sequences the once-per-frame game-object update for the ball datapath. Detects end of the active frame from the pixel coordinates and arbitrates the velocity-delta source between the buttons and the accelerometer. Issues an ordered series of update operations to the datapath over a valid/ready handshake. Sits between the coordinate/input sources and the ball position/speed registers.

Parameters:
H_LAST, 799, last active h_coord of a frame
V_LAST, 599, last active v_coord of a frame
FRAMES_PER_ACTION, 5, frames per decel period; frame_cnt counts 0..FRAMES_PER_ACTION-1
ACCEL_DEADZONE, 4, magnitude at or below which an accel axis reads as zero

Ports:
pixel_clk  in  1  pixel clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
h_coord  in  10  current pixel column
v_coord  in  10  current pixel row
button_u / button_d / button_l / button_r  in  1 each  direction buttons, active high
accel_x / accel_y  in  8  signed two's-complement tilt, already offset-corrected
upd_ready  in  1  datapath accepts current op
upd_valid  out  1  op and payload valid
upd_op  out  2  0=ACCEL, 1=MOVE, 2=COLLIDE, 3=DECEL
upd_dx / upd_dy  out  10  signed velocity delta, meaningful for ACCEL only
frame_cnt  out  3  current frame index within the action period
src_sel  out  1  latched delta source: 0=buttons, 1=accel
busy  out  1  FSM not in IDLE
overrun  out  1  sticky: an end-of-frame arrived while busy

Behaviour:
- Reset (async, rst_n=0): all outputs 0 and FSM=IDLE immediately. A mid-sequence reset drops upd_valid in the same instant; no partial op completes.
- eof_r is registered as (h_coord==H_LAST && v_coord==V_LAST). It is high for exactly one cycle, one cycle after the match.
- On eof_r: frame_cnt advances (FRAMES_PER_ACTION-1 wraps to 0) whether or not the FSM is busy.
- If eof_r occurs while busy, overrun is set (sticky until reset), that frame's update is dropped, nothing is queued, and the running sequence continues.
- If eof_r occurs in IDLE, the FSM latches buttons, accel, and action = (frame_cnt==0, pre-increment value), then moves to ACCEL.
- upd_valid is high the cycle after eof_r, i.e. 2 cycles after the coordinate match.
- FSM states: IDLE -> ACCEL -> MOVE -> COLLIDE -> DECEL -> IDLE.
  - DECEL is entered only if action is set; otherwise COLLIDE -> IDLE.
  - Each non-IDLE state drives upd_valid=1 with its op code.
  - The state advances on the edge where upd_valid && upd_ready.
  - With ready held high, ops issue on consecutive cycles and upd_valid stays continuously high.
  - The last transfer returns the FSM to IDLE with upd_valid=0 the next cycle.
- Handshake: upd_op, upd_dx and upd_dy are held stable while valid && !ready. upd_valid never drops before the transfer.
- Arbitration uses latched inputs:
  - Any button pressed -> src_sel=0, dx = r - l, dy = d - u (each in {-1,0,+1}; opposite buttons cancel to 0).
  - Otherwise src_sel=1, each axis = 0 if |a| <= ACCEL_DEADZONE, else (a >>> 4) sign-extended to 10 bits, with a minimum magnitude of 1 carrying a's sign.
  - |-128| is treated as 127.
- upd_dx and upd_dy are 0 when upd_op != ACCEL.

Optional Feature:
FRAME_SCHED_COLLIDE_EN
- Defined: the COLLIDE state and op=2 are issued as described.
- Undefined: the COLLIDE state is absent and the sequence is ACCEL -> MOVE -> (DECEL) -> IDLE. op=2 never appears and the sequence is one transfer shorter.

Decomposition:
- Package frame_sched_pkg: op_e enum (ACCEL/MOVE/COLLIDE/DECEL), state_e enum, default H_LAST/V_LAST constants, OP_W=2, DELTA_W=10.
- One sub-module, delta_arbiter: combinational button/accel priority, deadzone and sign-extension. Instantiated once on the latched inputs.

Test Plan:
1. Reset, then drive h=799, v=599 for one cycle with ready=1 and frame_cnt=0 -> upd_valid rises 2 cycles after the match; ops 0,1,2,3 on consecutive cycles; busy falls after DECEL; frame_cnt=1.
2. Frame with frame_cnt=1 -> ops 0,1,2 only, no DECEL; frame_cnt=2. Over 5 frames, DECEL appears only in the frame latched at frame_cnt=0.
3. button_r=1, button_l=1, button_d=1, accel_x=100 -> src_sel=0, upd_dx=0, upd_dy=+1. Release all buttons with accel_x=-128, accel_y=3 -> src_sel=1, dx=-8 (10'h3F8), dy=0.
4. ready=0 for 4 cycles during MOVE -> upd_op=1 held with valid high throughout; advances the cycle after ready=1.
5. Hold ready=0 across the next frame's match -> overrun=1 and stays 1; frame_cnt still increments; no second sequence starts.
6. Assert rst_n=0 asynchronously mid-COLLIDE -> upd_valid, busy and frame_cnt read 0 before the next clock edge. After release the FSM is in IDLE and the next eof starts cleanly at ACCEL.

Source files
------------

// File: rtl/frame_sched_pkg.sv
// Purpose : shared types and constants for the once-per-frame ball update scheduler.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: op_e (datapath op codes), state_e (sequencer states), OP_W, DELTA_W,
//           and the default end-of-active-frame coordinates.
package frame_sched_pkg;

    localparam int OP_W       = 2;
    localparam int DELTA_W    = 10;
    localparam int H_LAST_DEF = 799;
    localparam int V_LAST_DEF = 599;

    typedef enum logic [OP_W-1:0] {
        OP_ACCEL   = 2'd0,
        OP_MOVE    = 2'd1,
        OP_COLLIDE = 2'd2,
        OP_DECEL   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCEL   = 3'd1,
        S_MOVE    = 3'd2,
        S_COLLIDE = 3'd3,
        S_DECEL   = 3'd4
    } state_e;

endpackage

// File: rtl/delta_arbiter.sv
// Purpose : picks the ball velocity delta from buttons (priority) or accelerometer.
// Latency : combinational.
// Backpressure: none; outputs follow the (latched) inputs.
// Ports   : i_btn_u/d/l/r buttons, i_accel_x/y signed tilt;
//           o_src_sel (0=buttons, 1=accel), o_dx/o_dy signed deltas.
module delta_arbiter
    import frame_sched_pkg::*;
#(
    parameter int ACCEL_DEADZONE = 4
) (
    input  logic                      i_btn_u,
    input  logic                      i_btn_d,
    input  logic                      i_btn_l,
    input  logic                      i_btn_r,
    input  logic signed [7:0]         i_accel_x,
    input  logic signed [7:0]         i_accel_y,
    output logic                      o_src_sel,
    output logic signed [DELTA_W-1:0] o_dx,
    output logic signed [DELTA_W-1:0] o_dy
);

    localparam logic [7:0]                DZ     = ACCEL_DEADZONE[7:0];
    localparam logic signed [DELTA_W-1:0] D_POS1 = 10'sd1;
    localparam logic signed [DELTA_W-1:0] D_NEG1 = -10'sd1;
    localparam logic signed [DELTA_W-1:0] D_ZERO = 10'sd0;

    // One accelerometer axis: deadzone, coarse scale by 16, never round a
    // live tilt down to zero.
    function automatic logic signed [DELTA_W-1:0] axis_delta(input logic signed [7:0] a);
        logic [7:0]        mag;
        logic signed [7:0] shr;
        // -128 has no positive twin in 8 bits; clamp its magnitude to 127.
        if (a == -8'sd128)
            mag = 8'd127;
        else
            mag = a[7] ? (~a + 8'd1) : a;
        shr = a >>> 4;
        if (mag <= DZ)
            return D_ZERO;
        else if (shr == 8'sd0)
            return a[7] ? D_NEG1 : D_POS1;
        else
            return {{(DELTA_W-8){shr[7]}}, shr};
    endfunction

    logic w_any_btn;
    assign w_any_btn = i_btn_u | i_btn_d | i_btn_l | i_btn_r;

    always_comb begin
        o_src_sel = 1'b0;
        o_dx      = D_ZERO;
        o_dy      = D_ZERO;
        if (w_any_btn) begin
            // Opposite buttons cancel.
            if (i_btn_r && !i_btn_l)      o_dx = D_POS1;
            else if (i_btn_l && !i_btn_r) o_dx = D_NEG1;
            if (i_btn_d && !i_btn_u)      o_dy = D_POS1;
            else if (i_btn_u && !i_btn_d) o_dy = D_NEG1;
        end else begin
            o_src_sel = 1'b1;
            o_dx      = axis_delta(i_accel_x);
            o_dy      = axis_delta(i_accel_y);
        end
    end

endmodule

// File: rtl/frame_update_scheduler.sv
// Purpose : detects end of active frame and issues ACCEL/MOVE/[COLLIDE]/[DECEL] ops to the ball datapath.
// Latency : first op valid 2 cycles after the last-pixel coordinate match; one op per accepted transfer.
// Backpressure: upd_valid/upd_ready; op and payload held while !upd_ready; an end-of-frame while busy is dropped and flagged in sticky overrun.
// Ports   : pixel_clk, rst_n (async, active low); h_coord/v_coord; button_u/d/l/r; accel_x/y;
//           upd_ready in; upd_valid/upd_op/upd_dx/upd_dy, frame_cnt, src_sel, busy, overrun out.
// Build   : define FRAME_SCHED_COLLIDE_EN to include the COLLIDE op; otherwise it is skipped.
module frame_update_scheduler
    import frame_sched_pkg::*;
#(
    parameter int H_LAST            = H_LAST_DEF,
    parameter int V_LAST            = V_LAST_DEF,
    parameter int FRAMES_PER_ACTION = 5,
    parameter int ACCEL_DEADZONE    = 4
) (
    input  logic               pixel_clk,
    input  logic               rst_n,
    input  logic [9:0]         h_coord,
    input  logic [9:0]         v_coord,
    input  logic               button_u,
    input  logic               button_d,
    input  logic               button_l,
    input  logic               button_r,
    input  logic signed [7:0]  accel_x,
    input  logic signed [7:0]  accel_y,
    input  logic               upd_ready,
    output logic               upd_valid,
    output logic [OP_W-1:0]    upd_op,
    output logic [DELTA_W-1:0] upd_dx,
    output logic [DELTA_W-1:0] upd_dy,
    output logic [2:0]         frame_cnt,
    output logic               src_sel,
    output logic               busy,
    output logic               overrun
);

    localparam logic [9:0] H_L     = H_LAST[9:0];
    localparam logic [9:0] V_L     = V_LAST[9:0];
    localparam logic [2:0] FC_LAST = 3'(FRAMES_PER_ACTION - 1);

    state_e            r_state;
    op_e               r_op;
    logic              r_eof;
    logic              r_valid;
    logic              r_action;
    logic              r_seen;
    logic              r_overrun;
    logic [2:0]        r_frame_cnt;
    logic              r_btn_u, r_btn_d, r_btn_l, r_btn_r;
    logic signed [7:0] r_accel_x, r_accel_y;

    logic                      w_xfer;
    logic                      w_src_sel;
    logic signed [DELTA_W-1:0] w_dx, w_dy;

    assign w_xfer = r_valid & upd_ready;

    delta_arbiter #(
        .ACCEL_DEADZONE (ACCEL_DEADZONE)
    ) u_delta_arbiter (
        .i_btn_u   (r_btn_u),
        .i_btn_d   (r_btn_d),
        .i_btn_l   (r_btn_l),
        .i_btn_r   (r_btn_r),
        .i_accel_x (r_accel_x),
        .i_accel_y (r_accel_y),
        .o_src_sel (w_src_sel),
        .o_dx      (w_dx),
        .o_dy      (w_dy)
    );

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_ACCEL;
            r_eof       <= 1'b0;
            r_valid     <= 1'b0;
            r_action    <= 1'b0;
            r_seen      <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= 3'd0;
            r_btn_u     <= 1'b0;
            r_btn_d     <= 1'b0;
            r_btn_l     <= 1'b0;
            r_btn_r     <= 1'b0;
            r_accel_x   <= 8'sd0;
            r_accel_y   <= 8'sd0;
        end else begin
            r_eof <= (h_coord == H_L) && (v_coord == V_L);

            // Frame counting never stalls; a busy sequencer only loses the update.
            if (r_eof) begin
                r_frame_cnt <= (r_frame_cnt == FC_LAST) ? 3'd0 : r_frame_cnt + 3'd1;
                if (r_state != S_IDLE)
                    r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_eof) begin
                        r_btn_u   <= button_u;
                        r_btn_d   <= button_d;
                        r_btn_l   <= button_l;
                        r_btn_r   <= button_r;
                        r_accel_x <= accel_x;
                        r_accel_y <= accel_y;
                        r_action  <= (r_frame_cnt == 3'd0);
                        r_seen    <= 1'b1;
                        r_state   <= S_ACCEL;
                        r_op      <= OP_ACCEL;
                        r_valid   <= 1'b1;
                    end
                end
                S_ACCEL: begin
                    if (w_xfer) begin
                        r_state <= S_MOVE;
                        r_op    <= OP_MOVE;
                    end
                end
                S_MOVE: begin
                    if (w_xfer) begin
`ifdef FRAME_SCHED_COLLIDE_EN
                        r_state <= S_COLLIDE;
                        r_op    <= OP_COLLIDE;
`else
                        if (r_action) begin
                            r_state <= S_DECEL;
                            r_op    <= OP_DECEL;
                        end else begin
                            r_state <= S_IDLE;
                            r_op    <= OP_ACCEL;
                            r_valid <= 1'b0;
                        end
`endif
                    end
                end
`ifdef FRAME_SCHED_COLLIDE_EN
                S_COLLIDE: begin
                    if (w_xfer) begin
                        if (r_action) begin
                            r_state <= S_DECEL;
                            r_op    <= OP_DECEL;
                        end else begin
                            r_state <= S_IDLE;
                            r_op    <= OP_ACCEL;
                            r_valid <= 1'b0;
                        end
                    end
                end
`endif
                S_DECEL: begin
                    if (w_xfer) begin
                        r_state <= S_IDLE;
                        r_op    <= OP_ACCEL;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_op    <= OP_ACCEL;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign upd_valid = r_valid;
    assign upd_op    = r_op;
    // Deltas only travel with a live ACCEL op.
    assign upd_dx    = (r_valid && r_op == OP_ACCEL) ? w_dx : '0;
    assign upd_dy    = (r_valid && r_op == OP_ACCEL) ? w_dy : '0;
    assign frame_cnt = r_frame_cnt;
    // Reads 0 until the first frame has actually latched a source.
    assign src_sel   = r_seen & w_src_sel;
    assign busy      = (r_state != S_IDLE);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_frame_update_scheduler.sv
module tb_frame_update_scheduler;

    logic              pixel_clk = 1'b0;
    logic              rst_n;
    logic [9:0]        h_coord, v_coord;
    logic              button_u, button_d, button_l, button_r;
    logic signed [7:0] accel_x, accel_y;
    logic              upd_ready;
    logic              upd_valid;
    logic [1:0]        upd_op;
    logic [9:0]        upd_dx, upd_dy;
    logic [2:0]        frame_cnt;
    logic              src_sel, busy, overrun;

    frame_update_scheduler dut (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .h_coord   (h_coord),
        .v_coord   (v_coord),
        .button_u  (button_u),
        .button_d  (button_d),
        .button_l  (button_l),
        .button_r  (button_r),
        .accel_x   (accel_x),
        .accel_y   (accel_y),
        .upd_ready (upd_ready),
        .upd_valid (upd_valid),
        .upd_op    (upd_op),
        .upd_dx    (upd_dx),
        .upd_dy    (upd_dy),
        .frame_cnt (frame_cnt),
        .src_sel   (src_sel),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 pixel_clk = ~pixel_clk;

`ifdef FRAME_SCHED_COLLIDE_EN
    localparam bit COL_EN = 1'b1;
`else
    localparam bit COL_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int tb_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int op; int dx; int dy; } xfer_t;
    xfer_t m_q[$];
    int    m_fc      = 0;
    bit    m_ovr     = 1'b0;
    bit    m_src     = 1'b0;
    bit    m_match_d = 1'b0;

    function automatic int axis_model(input int a);
        int mag;
        int q;
        mag = (a == -128) ? 127 : ((a < 0) ? -a : a);
        if (mag <= 4) return 0;
        q = (a >= 0) ? (a / 16) : -((-a + 15) / 16);
        if (q == 0) q = (a > 0) ? 1 : -1;
        return q;
    endfunction

    always @(negedge pixel_clk) begin
        bit    was_busy;
        bit    any_btn;
        int    dx, dy;
        logic [31:0] exp_dx, exp_dy;
        if (!rst_n) begin
            m_q.delete();
            m_fc = 0; m_ovr = 0; m_src = 0; m_match_d = 0;
        end
        check("m_valid",   upd_valid, (m_q.size() > 0));
        check("m_busy",    busy,      (m_q.size() > 0));
        check("m_frame",   frame_cnt, m_fc);
        check("m_overrun", overrun,   m_ovr);
        check("m_src",     src_sel,   m_src);
        exp_dx = 0; exp_dy = 0;
        if (m_q.size() > 0) begin
            check("m_op", upd_op, m_q[0].op);
            if (m_q[0].op == 0) begin
                exp_dx = 32'(m_q[0].dx) & 32'h3FF;
                exp_dy = 32'(m_q[0].dy) & 32'h3FF;
            end
        end
        check("m_dx", upd_dx, exp_dx);
        check("m_dy", upd_dy, exp_dy);
        if (rst_n) begin
            was_busy = (m_q.size() > 0);
            if (was_busy && upd_ready) void'(m_q.pop_front());
            if (m_match_d) begin
                if (was_busy) m_ovr = 1'b1;
                else begin
                    any_btn = button_u | button_d | button_l | button_r;
                    if (any_btn) begin
                        dx = int'(button_r) - int'(button_l);
                        dy = int'(button_d) - int'(button_u);
                        m_src = 1'b0;
                    end else begin
                        dx = axis_model(int'(accel_x));
                        dy = axis_model(int'(accel_y));
                        m_src = 1'b1;
                    end
                    m_q.push_back('{0, dx, dy});
                    m_q.push_back('{1, 0, 0});
                    if (COL_EN) m_q.push_back('{2, 0, 0});
                    if (m_fc == 0) m_q.push_back('{3, 0, 0});
                end
                m_fc = (m_fc + 1) % 5;
            end
            m_match_d = (h_coord == 10'd799) && (v_coord == 10'd599);
        end
    end

    // ---------------- stimulus helpers ----------------
    int          ops_seen[$];
    int          f_nops;
    bit          f_decel;
    logic [9:0]  f_dx, f_dy;
    logic        f_src;

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic pulse_match();
        h_coord = 10'd799; v_coord = 10'd599;
        tick();
        h_coord = 10'd0; v_coord = 10'd0;
        tb_frames++;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 20 && upd_valid; c++) tick();
        check(name, upd_valid, 0);
    endtask

    // One full frame with ready held high; records ops and first-op payload.
    task automatic run_frame();
        upd_ready = 1'b1;
        ops_seen.delete();
        pulse_match();
        check("lat_pre", upd_valid, 0);
        tick();
        check("lat_valid", upd_valid, 1);
        check("first_op", upd_op, 0);
        f_dx = upd_dx; f_dy = upd_dy; f_src = src_sel;
        f_nops = 0; f_decel = 1'b0;
        for (int c = 0; c < 20 && upd_valid; c++) begin
            ops_seen.push_back(int'(upd_op));
            f_nops++;
            if (upd_op == 2'd3) f_decel = 1'b1;
            tick();
        end
        check("frame_end", upd_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ops[$];
        rst_n = 1'b0;
        h_coord = 0; v_coord = 0;
        button_u = 0; button_d = 0; button_l = 0; button_r = 0;
        accel_x = 0; accel_y = 0;
        upd_ready = 1'b1;
        repeat (3) @(posedge pixel_clk);
        #1;
        check("rst_valid", upd_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_frame", frame_cnt, 0);
        check("rst_ovr",   overrun, 0);
        check("rst_src",   src_sel, 0);
        check("rst_dx",    upd_dx, 0);
        rst_n = 1'b1;
        tick();

        // Test 1: first frame at frame_cnt=0 issues the full sequence with DECEL.
        run_frame();
        exp_ops = {0, 1};
        if (COL_EN) exp_ops.push_back(2);
        exp_ops.push_back(3);
        check("t1_nops", f_nops, exp_ops.size());
        for (int i = 0; i < exp_ops.size() && i < ops_seen.size(); i++)
            check("t1_op", ops_seen[i], exp_ops[i]);
        check("t1_busy",  busy, 0);
        check("t1_frame", frame_cnt, 1);

        // Test 2: DECEL only in the frame latched at frame_cnt=0.
        for (int i = 0; i < 5; i++) begin
            run_frame();
            check("t2_decel", f_decel, (i == 4));
            check("t2_nops",  f_nops, (COL_EN ? 3 : 2) + ((i == 4) ? 1 : 0));
        end
        check("t2_frame", frame_cnt, 1);

        // Test 3: arbitration.
        button_r = 1; button_l = 1; button_d = 1; accel_x = 8'sd100;
        run_frame();
        check("t3a_src", f_src, 0);
        check("t3a_dx",  f_dx, 10'h000);
        check("t3a_dy",  f_dy, 10'h001);
        button_r = 0; button_l = 0; button_d = 0; accel_x = -8'sd128; accel_y = 8'sd3;
        run_frame();
        check("t3b_src", f_src, 1);
        check("t3b_dx",  f_dx, 10'h3F8);
        check("t3b_dy",  f_dy, 10'h000);
        accel_x = 8'sd20; accel_y = -8'sd5;
        run_frame();
        check("t3c_dx",  f_dx, 10'h001);
        check("t3c_dy",  f_dy, 10'h3FF);
        accel_x = 8'sd5; accel_y = -8'sd4;
        run_frame();
        check("t3d_dx",  f_dx, 10'h001);
        check("t3d_dy",  f_dy, 10'h000);
        button_u = 1;
        run_frame();
        check("t3e_src", f_src, 0);
        check("t3e_dy",  f_dy, 10'h3FF);
        button_u = 0; accel_x = 0; accel_y = 0;

        // Test 4: stall in MOVE.
        pulse_match();
        tick();
        check("t4_accel", upd_op, 0);
        tick();
        check("t4_move", upd_op, 1);
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_hold_valid", upd_valid, 1);
            check("t4_hold_op",    upd_op, 1);
        end
        upd_ready = 1'b1;
        tick();
        check("t4_advanced", (upd_valid && upd_op == 2'd1), 0);
        drain("t4_drain");

        // Test 5: end-of-frame while stalled -> overrun.
        pulse_match();
        tick();
        check("t5_start", upd_valid, 1);
        upd_ready = 1'b0;
        pulse_match();
        tick();
        check("t5_ovr",   overrun, 1);
        check("t5_frame", frame_cnt, tb_frames % 5);
        check("t5_op",    upd_op, 0);
        upd_ready = 1'b1;
        drain("t5_drain");
        repeat (4) tick();
        check("t5_no_restart", upd_valid, 0);
        check("t5_ovr_sticky", overrun, 1);

        // Test 6: async reset mid-sequence.
        pulse_match();
        tick();
        tick();
        if (COL_EN) tick();
        check("t6_pre_valid", upd_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", upd_valid, 0);
        check("t6_busy",  busy, 0);
        check("t6_frame", frame_cnt, 0);
        check("t6_ovr",   overrun, 0);
        tb_frames = 0;
        tick();
        rst_n = 1'b1;
        tick();
        run_frame();
        check("t6_decel", f_decel, 1);
        check("t6_frame_after", frame_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
